// File: rtl/cluster_pkg.sv
// Shared types, constants and helpers for the sequential S-bit cluster packer.
package cluster_pkg;

  localparam int CNT_BITS_D = 3;
  localparam int ADR_BITS_D = 11;
  localparam int W_D = CNT_BITS_D + ADR_BITS_D;

  localparam logic [ADR_BITS_D-1:0] INVALID_ADR = '1;

  typedef struct packed {
    logic [CNT_BITS_D-1:0] cnt;
    logic [ADR_BITS_D-1:0] adr;
  } cluster_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int clog2_min1(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/cluster_packer_seq_run_finder.sv
// Locates the lowest-address cluster in a work vector and builds its clear mask.
module run_finder
  import cluster_pkg::*;
#(
  parameter int NUM_SBITS      = 1536,
  parameter int PARTITION_SIZE = 192,
  parameter int CNT_BITS       = 3,
  parameter int ADR_BITS       = 11
) (
  input  logic [NUM_SBITS-1:0] work,
  input  logic                 truncate,
  output logic [ADR_BITS-1:0]  p,
  output logic [CNT_BITS:0]    len,
  output logic                 any,
  output logic [NUM_SBITS-1:0] mask
);

  localparam int PS     = PARTITION_SIZE;
  localparam int MAXLEN = 2 ** CNT_BITS;
  localparam int LLIM   = (MAXLEN < PS) ? MAXLEN : PS;

  logic [PS-1:0] win;
  logic          go;
  int            room;
  int            rlen;
  int            tlen;

  always_comb begin
    p   = '0;
    any = 1'b0;
    for (int i = NUM_SBITS - 1; i >= 0; i--) begin
      if (work[i]) begin
        p   = ADR_BITS'(i);
        any = 1'b1;
      end
    end

    // window starting at p; room = bits left before the partition edge
    win  = PS'(work >> p);
    room = (int'(p) / PS) * PS + PS - int'(p);

    rlen = 0;
    go   = any;
    for (int j = 0; j < LLIM; j++) begin
      if (go && j < room && win[j]) rlen = rlen + 1;
      else go = 1'b0;
    end

    tlen = 0;
    go   = any;
    for (int j = 0; j < PS; j++) begin
      if (go && j < room && win[j]) tlen = tlen + 1;
      else go = 1'b0;
    end

    len  = (CNT_BITS + 1)'(rlen);
    mask = ~({NUM_SBITS{1'b1}} << (truncate ? tlen : rlen)) << p;
  end

endmodule

// File: rtl/cluster_packer_seq.sv
// Sequential S-bit cluster packer: latch a frame, emit one cluster per cycle.
module cluster_packer_seq
  import cluster_pkg::*;
#(
  parameter int NUM_SBITS      = 1536,
  parameter int PARTITION_SIZE = 192,
  parameter int MAX_CLUSTERS   = 8,
  parameter int CNT_BITS       = 3,
  parameter int ADR_BITS       = 11,
  localparam int W  = CNT_BITS + ADR_BITS,
  localparam int NW = clog2_min1(MAX_CLUSTERS + 1)
) (
  input  logic                      clock4x,
  input  logic                      global_reset,
  input  logic [NUM_SBITS-1:0]      sbits_i,
  input  logic                      frame_valid_i,
  input  logic                      truncate_clusters,
  output logic                      frame_ready_o,
  output logic [MAX_CLUSTERS*W-1:0] clusters_o,
  output logic                      clusters_valid_o,
  output logic [NW-1:0]             num_clusters_o,
  output logic                      overflow_o,
  output logic [15:0]               dropped_frames_o
);

  localparam logic [W-1:0] EMPTY = {{CNT_BITS{1'b0}}, {ADR_BITS{1'b1}}};

  state_t               state;
  logic [NUM_SBITS-1:0] work;
  logic                 trunc;
  logic [NW-1:0]        k;
  logic [W-1:0]         stage    [MAX_CLUSTERS];
  logic [W-1:0]         stage_nx [MAX_CLUSTERS];
  logic [W-1:0]         slots    [MAX_CLUSTERS];

  logic [ADR_BITS-1:0]  p;
  logic [CNT_BITS:0]    len;
  logic                 any;
  logic [NUM_SBITS-1:0] mask;
  logic [NUM_SBITS-1:0] rest;
  logic                 last;

  run_finder #(
    .NUM_SBITS     (NUM_SBITS),
    .PARTITION_SIZE(PARTITION_SIZE),
    .CNT_BITS      (CNT_BITS),
    .ADR_BITS      (ADR_BITS)
  ) u_find (
    .work    (work),
    .truncate(trunc),
    .p       (p),
    .len     (len),
    .any     (any),
    .mask    (mask)
  );

  assign rest = work & ~mask;
  assign last = (rest == '0) || (k == NW'(MAX_CLUSTERS - 1));

  always_comb begin
    for (int s = 0; s < MAX_CLUSTERS; s++) begin
      stage_nx[s] = stage[s];
      if (k == NW'(s)) stage_nx[s] = {CNT_BITS'(len - 1'b1), p};
    end
  end

  for (genvar s = 0; s < MAX_CLUSTERS; s++) begin : g_out
    assign clusters_o[s*W +: W] = slots[s];
  end

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state            <= ST_IDLE;
      work             <= '0;
      trunc            <= 1'b0;
      k                <= '0;
      for (int s = 0; s < MAX_CLUSTERS; s++) begin
        stage[s] <= EMPTY;
        slots[s] <= EMPTY;
      end
      clusters_valid_o <= 1'b0;
      num_clusters_o   <= '0;
      overflow_o       <= 1'b0;
      dropped_frames_o <= '0;
      frame_ready_o    <= 1'b1;
    end else begin
      clusters_valid_o <= 1'b0;
      if (frame_valid_i && state != ST_IDLE && dropped_frames_o != 16'hFFFF)
        dropped_frames_o <= dropped_frames_o + 16'd1;

      case (state)
        ST_IDLE: begin
          if (frame_valid_i) begin
            work          <= sbits_i;
            trunc         <= truncate_clusters;
            k             <= '0;
            for (int s = 0; s < MAX_CLUSTERS; s++) stage[s] <= EMPTY;
            frame_ready_o <= 1'b0;
            state         <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!any) begin
            slots            <= stage;
            num_clusters_o   <= k;
            overflow_o       <= 1'b0;
            clusters_valid_o <= 1'b1;
            state            <= ST_DONE;
          end else begin
            stage <= stage_nx;
            work  <= rest;
            k     <= k + 1'b1;
            // publish together with the slot written this cycle
            if (last) begin
              slots            <= stage_nx;
              num_clusters_o   <= k + 1'b1;
              overflow_o       <= |rest;
              clusters_valid_o <= 1'b1;
              state            <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          frame_ready_o <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          frame_ready_o <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_packer_seq.sv
// Directed and randomized checks of cluster_packer_seq against a queue-free loop model.
module tb_cluster_packer_seq;
  import cluster_pkg::*;

  localparam int N  = 1536;
  localparam int PS = 192;
  localparam int MC = 8;
  localparam int CB = 3;
  localparam int AB = 11;
  localparam int W  = CB + AB;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  sbits;
  logic          fv;
  logic          trunc;
  logic          ready;
  logic [MC*W-1:0] clusters;
  logic          cvalid;
  logic [3:0]    num;
  logic          ovf;
  logic [15:0]   dropped;

  always #5 clk = ~clk;

  cluster_packer_seq dut (
    .clock4x          (clk),
    .global_reset     (rst),
    .sbits_i          (sbits),
    .frame_valid_i    (fv),
    .truncate_clusters(trunc),
    .frame_ready_o    (ready),
    .clusters_o       (clusters),
    .clusters_valid_o (cvalid),
    .num_clusters_o   (num),
    .overflow_o       (ovf),
    .dropped_frames_o (dropped)
  );

  int       total  = 0;
  int       passed = 0;
  int       fails  = 0;
  cluster_t exp_slot [MC];
  int       exp_n;
  logic     exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // clusters found by walking the frame bit by bit
  task automatic model(input logic [N-1:0] f, input logic t);
    logic [N-1:0] w;
    int p, len, i;
    w = f;
    exp_n = 0;
    for (int s = 0; s < MC; s++) begin
      exp_slot[s].cnt = '0;
      exp_slot[s].adr = '1;
    end
    while (exp_n < MC && w != '0) begin
      p = 0;
      while (!w[p]) p++;
      len = 0;
      while (len < 2 ** CB && p + len < N && (p + len) / PS == p / PS && w[p+len])
        len++;
      exp_slot[exp_n].cnt = CB'(len - 1);
      exp_slot[exp_n].adr = AB'(p);
      for (i = p; i < p + len; i++) w[i] = 1'b0;
      if (t) begin
        while (i < N && i / PS == p / PS && w[i]) begin
          w[i] = 1'b0;
          i++;
        end
      end
      exp_n++;
    end
    exp_ovf = (w != '0);
  endtask

  task automatic check_empty(input string tag);
    for (int s = 0; s < MC; s++)
      check({tag, ".slot"}, 32'(clusters[s*W +: W]), 32'({3'd0, 11'h7FF}));
  endtask

  task automatic run_frame(input string tag, input logic [N-1:0] f, input logic t);
    int cyc;
    model(f, t);
    sbits = f;
    trunc = t;
    fv    = 1'b1;
    @(posedge clk);
    #1 fv = 1'b0;
    check({tag, ".ready_scan"}, 32'(ready), 32'd0);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!cvalid && cyc < 20);
    check({tag, ".latency"}, 32'(cyc + 1), 32'(((exp_n > 1) ? exp_n : 1) + 1));
    check({tag, ".num"}, 32'(num), 32'(exp_n));
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    for (int s = 0; s < MC; s++)
      check({tag, ".slot"}, 32'(clusters[s*W +: W]), 32'(exp_slot[s]));
    @(posedge clk);
    #1;
    check({tag, ".valid_low"}, 32'(cvalid), 32'd0);
    check({tag, ".ready_idle"}, 32'(ready), 32'd1);
    check({tag, ".hold"}, 32'(clusters[0 +: W]), 32'(exp_slot[0]));
  endtask

  initial begin
    logic [N-1:0] f;
    int cyc, mode, st, ln, b;
    logic saw;

    rst   = 1'b1;
    fv    = 1'b0;
    trunc = 1'b0;
    sbits = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.valid", 32'(cvalid), 32'd0);
    check("rst.num", 32'(num), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    check("rst.dropped", 32'(dropped), 32'd0);
    check_empty("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    f = '0;
    f[3:2] = 2'b11;
    run_frame("b23", f, 1'b1);
    check("b23.slot0_const", 32'(clusters[0 +: W]), 32'({3'd1, 11'd2}));

    f = '0;
    f[35:0] = 36'h0ff0ff0ff;
    run_frame("ff", f, 1'b1);
    check("ff.slot1_const", 32'(clusters[W +: W]), 32'({3'd7, 11'd12}));

    f = '0;
    f[11:0] = '1;
    run_frame("t12", f, 1'b1);
    check("t12.num_const", 32'(num), 32'd1);
    run_frame("s12", f, 1'b0);
    check("s12.slot1_const", 32'(clusters[W +: W]), 32'({3'd3, 11'd8}));

    f = '0;
    f[193:190] = '1;
    run_frame("pb", f, 1'b0);
    check("pb.slot1_const", 32'(clusters[W +: W]), 32'({3'd1, 11'd192}));

    f = '0;
    f[35:0] = 36'hAAAAAAAAA;
    run_frame("alt", f, 1'b1);
    check("alt.ovf_const", 32'(ovf), 32'd1);

    f = '0;
    run_frame("zero", f, 1'b0);

    // frames offered during a scan are dropped
    f = '0;
    f[35:0] = 36'hAAAAAAAAA;
    sbits = f;
    trunc = 1'b1;
    fv    = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("drop.ready_scan", 32'(ready), 32'd0);
      @(posedge clk);
      #1;
    end
    fv  = 1'b0;
    cyc = 0;
    while (!cvalid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drop.valid_seen", 32'(cvalid), 32'd1);
    check("drop.count", 32'(dropped), 32'd3);
    @(posedge clk);
    #1;

    // reset in the second scan cycle discards the frame
    sbits = f;
    fv    = 1'b1;
    @(posedge clk);
    #1 fv = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst.valid", 32'(cvalid), 32'd0);
    check("mrst.num", 32'(num), 32'd0);
    check("mrst.ovf", 32'(ovf), 32'd0);
    check("mrst.dropped", 32'(dropped), 32'd0);
    check("mrst.ready", 32'(ready), 32'd1);
    check_empty("mrst");
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (cvalid) saw = 1'b1;
    end
    check("mrst.no_pulse", 32'(saw), 32'd0);

    for (int r = 0; r < 40; r++) begin
      f    = '0;
      mode = $urandom_range(0, 3);
      if (mode == 0 || mode == 3) begin
        for (int wd = 0; wd < N / 32; wd++)
          f[wd*32 +: 32] = $urandom & $urandom & $urandom & $urandom;
      end
      if (mode == 1 || mode == 3) begin
        for (int q = 0; q < 4; q++) begin
          st = $urandom_range(0, N - 20);
          ln = $urandom_range(1, 18);
          for (int j = 0; j < ln; j++) f[st+j] = 1'b1;
        end
      end
      if (mode == 2) begin
        b = PS * $urandom_range(1, N / PS - 1);
        for (int j = -10; j < 10; j++) f[b+j] = 1'($urandom_range(0, 3) != 0);
      end
      run_frame("rnd", f, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
